// File: rtl/rcpu_irq_pkg.sv
// Shared definitions for the RCPU vectored interrupt controller.
package rcpu_irq_pkg;

   // Controller service states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_REQ  = 2'd2
   } state_t;

   // Register offsets on the cfg port
   localparam logic [1:0] REG_MASK   = 2'd0;
   localparam logic [1:0] REG_PEND   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_SWTRIG = 2'd3;

   // STATUS layout: busy flag and active-index field width
   localparam int unsigned STATUS_BUSY_BIT = 15;
   localparam int unsigned IDX_W           = 4;

endpackage

// File: rtl/rcpu_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of i_vec.
module rcpu_prio_enc
   import rcpu_irq_pkg::*;
#(
   parameter int unsigned NCH = 8
) (
   input  logic [NCH-1:0]   i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   // Scan downward so the lowest set index is the last one written
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (i_vec[k]) begin
            o_idx   = IDX_W'(k);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rcpu_irq_ctrl.sv
// Vectored interrupt controller for the RCPU single-line interrupt port.
// Build option: define RCPU_IRQ_EDGE_EN for rising-edge source detection;
// otherwise sources are level-sensitive.
module rcpu_irq_ctrl
   import rcpu_irq_pkg::*;
#(
   parameter int unsigned   NCH        = 8,
   parameter int unsigned   M          = 16,
   parameter int unsigned   N          = 32,
   parameter logic [N-1:0]  VEC_BASE   = N'(32'h0000_F000),
   parameter int unsigned   VEC_STRIDE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   src_irq,
   input  logic [NCH*M-1:0] src_data,
   output logic             irq,
   input  logic             turnOffIRQ,
   output logic [N-1:0]     intAddr,
   output logic [M-1:0]     intData,
   input  logic             cfg_we,
   input  logic             cfg_re,
   input  logic [1:0]       cfg_addr,
   input  logic [M-1:0]     cfg_wdata,
   output logic [M-1:0]     cfg_rdata
);

   state_t           r_state;
   logic [NCH-1:0]   r_pend;
   logic [NCH-1:0]   r_mask;
   logic [IDX_W-1:0] r_active;
   logic             r_irq;
   logic [N-1:0]     r_int_addr;
   logic [M-1:0]     r_int_data;
   logic [M-1:0]     r_rdata;

   logic [NCH-1:0]   w_det;
   logic [NCH-1:0]   w_set;
   logic [NCH-1:0]   w_clr;
   logic [NCH-1:0]   w_pend_nxt;
   logic [NCH-1:0]   w_pend_req;
   logic [NCH-1:0]   w_active_oh;
   logic [IDX_W-1:0] w_win_idx;
   logic             w_win_valid;
   logic             w_ack;
   logic             w_wr_mask;
   logic             w_wr_pend;
   logic             w_wr_swtrig;
   logic [N-1:0]     w_vec_addr;
   logic [M-1:0]     w_sel_data;
   logic [M-1:0]     w_status;
   logic [M-1:0]     w_rd_val;
   logic             w_unused;

   // Bits of cfg_wdata above NCH are intentionally ignored
   assign w_unused = ^cfg_wdata;

`ifdef RCPU_IRQ_EDGE_EN
   logic [NCH-1:0] r_src_prev;

   // Previous-cycle copy of the sources for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_src_prev <= '0;
      else     r_src_prev <= src_irq;
   end

   assign w_det = src_irq & ~r_src_prev;
`else
   assign w_det = src_irq;
`endif

   // Register-port decode and acknowledge qualification
   assign w_wr_mask   = cfg_we && (cfg_addr == REG_MASK);
   assign w_wr_pend   = cfg_we && (cfg_addr == REG_PEND);
   assign w_wr_swtrig = cfg_we && (cfg_addr == REG_SWTRIG);
   assign w_ack       = (r_state == ST_REQ) && turnOffIRQ;

   // Pending update: clears first, then sets so a same-cycle set wins
   assign w_active_oh = NCH'(1) << r_active;
   assign w_set       = w_det | (w_wr_swtrig ? cfg_wdata[NCH-1:0] : '0);
   assign w_clr       = (w_wr_pend ? cfg_wdata[NCH-1:0] : '0) | (w_ack ? w_active_oh : '0);
   assign w_pend_nxt  = (r_pend & ~w_clr) | w_set;

   // Arbitration runs on the registered mask, so a same-cycle MASK write is not yet visible
   assign w_pend_req = r_pend & r_mask;

   rcpu_prio_enc #(
      .NCH (NCH)
   ) u_prio_enc (
      .i_vec   (w_pend_req),
      .o_idx   (w_win_idx),
      .o_valid (w_win_valid)
   );

   // Vector address and data word of the active channel
   assign w_vec_addr = VEC_BASE + N'(r_active) * N'(VEC_STRIDE);
   assign w_sel_data = src_data[32'(r_active) * M +: M];

   // STATUS word: busy flag plus active index
   always_comb begin
      w_status                  = '0;
      w_status[IDX_W-1:0]       = r_active;
      w_status[STATUS_BUSY_BIT] = (r_state != ST_IDLE);
   end

   // Read-data mux; SWTRIG is write-only and reads zero
   always_comb begin
      w_rd_val = '0;
      case (cfg_addr)
         REG_MASK:   w_rd_val = M'(r_mask);
         REG_PEND:   w_rd_val = M'(r_pend);
         REG_STATUS: w_rd_val = w_status;
         default:    w_rd_val = '0;
      endcase
   end

   // Pending, mask and read-data registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend  <= '0;
         r_mask  <= '0;
         r_rdata <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         if (w_wr_mask) r_mask  <= cfg_wdata[NCH-1:0];
         if (cfg_re)    r_rdata <= w_rd_val;
      end
   end

   // Service FSM: pick winner, present vector, hold until acknowledge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_active   <= '0;
         r_irq      <= 1'b0;
         r_int_addr <= '0;
         r_int_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_win_valid) begin
                  r_active <= w_win_idx;
                  r_state  <= ST_ARB;
               end
            end
            ST_ARB: begin
               r_int_addr <= w_vec_addr;
               r_int_data <= w_sel_data;
               r_irq      <= 1'b1;
               r_state    <= ST_REQ;
            end
            ST_REQ: begin
               if (turnOffIRQ) begin
                  r_irq   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign irq       = r_irq;
   assign intAddr   = r_int_addr;
   assign intData   = r_int_data;
   assign cfg_rdata = r_rdata;

endmodule

// File: tb/tb_rcpu_irq_ctrl.sv
// Self-checking bench for rcpu_irq_ctrl: behavioural model plus directed scenarios.
module tb_rcpu_irq_ctrl;

   localparam int unsigned NCH        = 8;
   localparam int unsigned M          = 16;
   localparam int unsigned N          = 32;
   localparam logic [N-1:0] VEC_BASE  = 32'h0000_F000;
   localparam int unsigned VEC_STRIDE = 4;

   logic             clk;
   logic             rst;
   logic [NCH-1:0]   src_irq;
   logic [NCH*M-1:0] src_data;
   logic             irq;
   logic             turnOffIRQ;
   logic [N-1:0]     intAddr;
   logic [M-1:0]     intData;
   logic             cfg_we;
   logic             cfg_re;
   logic [1:0]       cfg_addr;
   logic [M-1:0]     cfg_wdata;
   logic [M-1:0]     cfg_rdata;

   rcpu_irq_ctrl #(
      .NCH        (NCH),
      .M          (M),
      .N          (N),
      .VEC_BASE   (VEC_BASE),
      .VEC_STRIDE (VEC_STRIDE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .src_irq    (src_irq),
      .src_data   (src_data),
      .irq        (irq),
      .turnOffIRQ (turnOffIRQ),
      .intAddr    (intAddr),
      .intData    (intData),
      .cfg_we     (cfg_we),
      .cfg_re     (cfg_re),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A channel is "pending" until served or cleared; service of the chosen
   // channel takes one selection cycle, then the request is shown until acked.
   bit           m_pend [NCH];
   bit           m_mask [NCH];
   bit           m_prev [NCH];
   int           m_cur   = 0;
   int           m_phase = 0;   // 0 free, 1 channel chosen, 2 request shown
   logic         m_irq   = 1'b0;
   logic [N-1:0] m_addr  = '0;
   logic [M-1:0] m_data  = '0;
   logic [M-1:0] m_rdata = '0;

   function automatic logic [M-1:0] pack_bits(input bit b [NCH]);
      logic [M-1:0] v = '0;
      for (int k = 0; k < NCH; k++) v[k] = b[k];
      return v;
   endfunction

   always @(posedge clk) begin : model
      int win;
      bit ack;
      bit raise;
      bit np [NCH];
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            m_pend[k] = 1'b0; m_mask[k] = 1'b0; m_prev[k] = 1'b0;
         end
         m_cur = 0; m_phase = 0; m_irq = 1'b0;
         m_addr = '0; m_data = '0; m_rdata = '0;
      end else begin
         ack = (m_phase == 2) && turnOffIRQ;
         win = -1;
         for (int k = 0; k < NCH; k++)
            if (m_pend[k] && m_mask[k] && win < 0) win = k;
         if (cfg_re) begin
            case (cfg_addr)
               2'd0: m_rdata = pack_bits(m_mask);
               2'd1: m_rdata = pack_bits(m_pend);
               2'd2: m_rdata = ((m_phase != 0) ? 16'h8000 : 16'h0000) | 16'(m_cur);
               default: m_rdata = '0;
            endcase
         end
         for (int k = 0; k < NCH; k++) begin
            np[k] = m_pend[k];
            if (cfg_we && cfg_addr == 2'd1 && cfg_wdata[k]) np[k] = 1'b0;
            if (ack && k == m_cur) np[k] = 1'b0;
`ifdef RCPU_IRQ_EDGE_EN
            raise = src_irq[k] && !m_prev[k];
`else
            raise = src_irq[k];
`endif
            if (raise || (cfg_we && cfg_addr == 2'd3 && cfg_wdata[k])) np[k] = 1'b1;
         end
         case (m_phase)
            0: if (win >= 0) begin m_cur = win; m_phase = 1; end
            1: begin
               m_irq   = 1'b1;
               m_addr  = VEC_BASE + 32'(m_cur * VEC_STRIDE);
               m_data  = src_data[m_cur*M +: M];
               m_phase = 2;
            end
            default: if (ack) begin m_irq = 1'b0; m_phase = 0; end
         endcase
         for (int k = 0; k < NCH; k++) begin
            if (cfg_we && cfg_addr == 2'd0) m_mask[k] = cfg_wdata[k];
            m_pend[k] = np[k];
            m_prev[k] = src_irq[k];
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      chk("cyc_irq",   64'(irq),       64'(m_irq));
      chk("cyc_addr",  64'(intAddr),   64'(m_addr));
      chk("cyc_data",  64'(intData),   64'(m_data));
      chk("cyc_rdata", 64'(cfg_rdata), 64'(m_rdata));
   end

   // ---------------- stimulus helpers (called at negedge) ----------------
   task automatic pulse_src(input int k);
      src_irq[k] = 1'b1;
      @(negedge clk);
      src_irq[k] = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [M-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic cfg_read(input logic [1:0] a, output logic [M-1:0] d);
      cfg_re = 1'b1; cfg_addr = a;
      @(negedge clk);
      cfg_re = 1'b0;
      d = cfg_rdata;
   endtask

   task automatic do_ack();
      turnOffIRQ = 1'b1;
      @(negedge clk);
      turnOffIRQ = 1'b0;
   endtask

   task automatic wait_irq(input string name, input int maxc);
      int c = 0;
      while (!irq && c < maxc) begin
         @(negedge clk);
         c++;
      end
      if (!irq) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: irq timeout, got 0 expected 1 within %0d cycles", name, maxc);
      end
   endtask

   task automatic drain();
      repeat (10) begin
         @(negedge clk);
         turnOffIRQ = irq;
      end
      @(negedge clk);
      turnOffIRQ = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      logic [M-1:0] rd;
      int           nreq;
      logic         prev_irq;

      rst = 1'b1; src_irq = '0; turnOffIRQ = 1'b0;
      cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      for (int k = 0; k < NCH; k++)
         src_data[k*M +: M] = 16'hD000 | 16'(k << 4) | 16'(k);

      repeat (3) @(negedge clk);
      chk("rst_irq",   64'(irq),       64'h0);
      chk("rst_addr",  64'(intAddr),   64'h0);
      chk("rst_data",  64'(intData),   64'h0);
      chk("rst_rdata", 64'(cfg_rdata), 64'h0);
      rst = 1'b0;
      @(negedge clk);
      cfg_write(2'd0, 16'h00FF);

      // 1: single pulse on channel 5, two-cycle latency
      pulse_src(5);
      @(negedge clk);
      chk("t1_irq_t1", 64'(irq), 64'h0);
      @(negedge clk);
      chk("t1_irq_t2", 64'(irq),     64'h1);
      chk("t1_addr",   64'(intAddr), 64'h0000_F014);
      chk("t1_data",   64'(intData), 64'hD055);
      do_ack();
      chk("t1_irq_ack", 64'(irq), 64'h0);
      cfg_read(2'd1, rd);
      chk("t1_pend", 64'(rd), 64'h0);
      repeat (2) @(negedge clk);

      // 2: channels 2 and 6 together, lowest index first
      src_irq[2] = 1'b1; src_irq[6] = 1'b1;
      @(negedge clk);
      src_irq = '0;
      wait_irq("t2_first", 6);
      chk("t2_addr0", 64'(intAddr), 64'h0000_F008);
      chk("t2_data0", 64'(intData), 64'hD022);
      do_ack();
      chk("t2_irq_a0", 64'(irq), 64'h0);
      @(negedge clk);
      chk("t2_irq_a1", 64'(irq), 64'h0);
      @(negedge clk);
      chk("t2_irq_a2", 64'(irq),     64'h1);
      chk("t2_addr1",  64'(intAddr), 64'h0000_F018);
      chk("t2_data1",  64'(intData), 64'hD066);
      do_ack();
      repeat (2) @(negedge clk);

      // 3: masked channel 3, then unmask
      cfg_write(2'd0, 16'h0000);
      pulse_src(3);
      repeat (4) @(negedge clk);
      chk("t3_masked_irq", 64'(irq), 64'h0);
      cfg_read(2'd1, rd);
      chk("t3_pend", 64'(rd), 64'h08);
      cfg_write(2'd0, 16'h0008);
      chk("t3_irq_w0", 64'(irq), 64'h0);
      @(negedge clk);
      chk("t3_irq_w1", 64'(irq), 64'h0);
      @(negedge clk);
      chk("t3_irq_w2", 64'(irq),     64'h1);
      chk("t3_addr",   64'(intAddr), 64'h0000_F00C);
      do_ack();
      cfg_write(2'd0, 16'h00FF);
      repeat (2) @(negedge clk);

      // 4: clear pending and mask under an outstanding request
      pulse_src(1);
      wait_irq("t4_req", 6);
      chk("t4_addr0", 64'(intAddr), 64'h0000_F004);
      cfg_write(2'd1, 16'h0002);
      cfg_write(2'd0, 16'h0000);
      repeat (3) @(negedge clk);
      chk("t4_irq_hold",  64'(irq),     64'h1);
      chk("t4_addr_hold", 64'(intAddr), 64'h0000_F004);
      cfg_read(2'd2, rd);
      chk("t4_status", 64'(rd), 64'h8001);
      do_ack();
      chk("t4_irq_ack", 64'(irq), 64'h0);
      repeat (3) @(negedge clk);
      chk("t4_irq_quiet", 64'(irq), 64'h0);
      cfg_read(2'd2, rd);
      chk("t4_status_idle", 64'(rd), 64'h0001);

      // Register-width and software-trigger boundaries
      cfg_write(2'd0, 16'hFFFF);
      cfg_read(2'd0, rd);
      chk("mask_width", 64'(rd), 64'h00FF);
      cfg_write(2'd3, 16'hFF00);
      repeat (3) @(negedge clk);
      chk("swtrig_hi_irq", 64'(irq), 64'h0);
      cfg_read(2'd1, rd);
      chk("swtrig_hi_pend", 64'(rd), 64'h0);
      cfg_write(2'd3, 16'h0080);
      wait_irq("swtrig_req", 6);
      chk("swtrig_addr", 64'(intAddr), 64'h0000_F01C);
      chk("swtrig_data", 64'(intData), 64'hD077);
      do_ack();
      repeat (2) @(negedge clk);

      // 5: source 0 held high for 20 cycles, acked as soon as seen
      nreq = 0; prev_irq = 1'b0;
      src_irq[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (irq && !prev_irq) nreq++;
         prev_irq   = irq;
         turnOffIRQ = irq;
      end
      src_irq[0] = 1'b0;
      turnOffIRQ = 1'b0;
`ifdef RCPU_IRQ_EDGE_EN
      chk("t5_requests", 64'(nreq), 64'd1);
`else
      chk("t5_requests", 64'(nreq), 64'd6);
`endif
      drain();
      chk("t5_irq_end", 64'(irq), 64'h0);
      cfg_read(2'd1, rd);
      chk("t5_pend_end", 64'(rd), 64'h0);

      // 6: asynchronous reset while a request is shown
      pulse_src(4);
      wait_irq("t6_req", 6);
      chk("t6_addr", 64'(intAddr), 64'h0000_F010);
      #2 rst = 1'b1;
      #1;
      chk("t6_irq_async",  64'(irq),     64'h0);
      chk("t6_addr_async", 64'(intAddr), 64'h0);
      chk("t6_data_async", 64'(intData), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cfg_read(2'd0, rd);
      chk("t6_mask", 64'(rd), 64'h0);
      cfg_read(2'd2, rd);
      chk("t6_status", 64'(rd), 64'h0);
      cfg_read(2'd1, rd);
      chk("t6_pend", 64'(rd), 64'h0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
